// File: rtl/uart_core_ctrl_pkg.sv
// Shared types and constants for the CoreUART sequencer/arbiter.
// Holds the controller state encoding and the settle-counter width.
package uart_ctrl_pkg;

    localparam int SETTLE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_WAIT,
        RD,
        RD_WAIT
    } ctrl_state_e;

    // A single requester still needs a one-bit index.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_core_ctrl_if.sv
// Bundle of requester, RX stream, statistics and UART_CORE bus signals.
// The controller uses the master modport; its environment uses slave.
interface uart_core_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_ready;

    logic                 err_clr;
    logic                 overflow_sticky;
    logic [CNT_W-1:0]     perr_cnt;
    logic [CNT_W-1:0]     ferr_cnt;

    logic                 uart_csn;
    logic                 uart_wen;
    logic                 uart_oen;
    logic [7:0]           uart_data_in;
    logic [7:0]           uart_data_out;
    logic                 uart_txrdy;
    logic                 uart_rxrdy;
    logic                 uart_perr;
    logic                 uart_ferr;
    logic                 uart_ovf;

    modport master (
        input  req_valid, req_data, rx_ready, err_clr,
        input  uart_data_out, uart_txrdy, uart_rxrdy, uart_perr, uart_ferr, uart_ovf,
        output req_ready, rx_valid, rx_data, rx_perr, rx_ferr,
        output overflow_sticky, perr_cnt, ferr_cnt,
        output uart_csn, uart_wen, uart_oen, uart_data_in
    );

    modport slave (
        output req_valid, req_data, rx_ready, err_clr,
        output uart_data_out, uart_txrdy, uart_rxrdy, uart_perr, uart_ferr, uart_ovf,
        input  req_ready, rx_valid, rx_data, rx_perr, rx_ferr,
        input  overflow_sticky, perr_cnt, ferr_cnt,
        input  uart_csn, uart_wen, uart_oen, uart_data_in
    );

endinterface

// File: rtl/uart_core_ctrl_rr_arbiter.sv
// Round-robin grant selection: first valid requester at or after the pointer.
// The pointer moves to one past the accepted index when a write is accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               accept_i,
    input  logic [IDX_W-1:0]   accept_idx_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_valid_o
);

    localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ-1);

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W:0]       offset;
    logic [IDX_W:0]       sum;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign doubled     = {req_valid_i, req_valid_i} >> ptr_q;
    assign rotated     = doubled[NUM_REQ-1:0];
    assign any_valid_o = |req_valid_i;

    always_comb begin
        offset = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = (IDX_W+1)'(i);
            end
        end
        sum = {1'b0, ptr_q} + offset;
        if (sum >= NUM_W) begin
            sum = sum - NUM_W;
        end
        grant_o = sum[IDX_W-1:0];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (accept_idx_i == LAST_IDX) ? '0 : accept_idx_i + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_core_ctrl.sv
// Sequencer for a FIFO-less CoreUART: arbitrates TX requesters onto the
// write strobe, drains RX bytes into a valid/ready stream, tracks errors.
module uart_core_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    uart_core_ctrl_if.master bus
);

    localparam int                  IDX_W       = idxWidth(NUM_REQ);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE-1);

    ctrl_state_e         state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    arb_grant;
    logic                arb_any;
    logic                accept;

    logic                csn_q, csn_d;
    logic                wen_q, wen_d;
    logic                oen_q, oen_d;
    logic [7:0]          data_in_q, data_in_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;

    logic                rx_valid_q, rx_valid_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_perr_q, rx_perr_d;
    logic                rx_ferr_q, rx_ferr_d;

    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    perr_cnt_q, perr_cnt_d;
    logic [CNT_W-1:0]    ferr_cnt_q, ferr_cnt_d;

    assign accept = (state_q == WR);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk_i        (CLK),
        .rst_n_i      (RESET_N),
        .req_valid_i  (bus.req_valid),
        .accept_i     (accept),
        .accept_idx_i (grant_q),
        .grant_o      (arb_grant),
        .any_valid_o  (arb_any)
    );

    // Strobes are computed one state ahead so every UART-facing pin is a flop.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        grant_d     = grant_q;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        oen_d       = 1'b1;
        data_in_d   = data_in_q;
        req_ready_d = '0;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_perr_d   = rx_perr_q;
        rx_ferr_d   = rx_ferr_q;
        ovf_d       = ovf_q;
        perr_cnt_d  = perr_cnt_q;
        ferr_cnt_d  = ferr_cnt_q;

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                settle_d = '0;
                if (bus.uart_rxrdy && !rx_valid_q) begin
                    state_d = RD;
                end else if (bus.uart_txrdy && arb_any) begin
                    state_d = WR;
                    grant_d = arb_grant;
                end
            end
            WR: begin
                csn_d = 1'b0;
                wen_d = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        data_in_d      = bus.req_data[8*i +: 8];
                        req_ready_d[i] = 1'b1;
                    end
                end
                settle_d = '0;
                state_d  = WR_WAIT;
            end
            RD: begin
                csn_d      = 1'b0;
                oen_d      = 1'b0;
                rx_valid_d = 1'b1;
                rx_data_d  = bus.uart_data_out;
                rx_perr_d  = bus.uart_perr;
                rx_ferr_d  = bus.uart_ferr;
                if (bus.uart_perr && (perr_cnt_q != '1)) begin
                    perr_cnt_d = perr_cnt_q + CNT_W'(1);
                end
                if (bus.uart_ferr && (ferr_cnt_q != '1)) begin
                    ferr_cnt_d = ferr_cnt_q + CNT_W'(1);
                end
                settle_d = '0;
                state_d  = RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = IDLE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.uart_ovf) begin
            ovf_d = 1'b1;
        end
        if (bus.err_clr) begin
            ovf_d      = 1'b0;
            perr_cnt_d = '0;
            ferr_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            grant_q     <= '0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            data_in_q   <= '0;
            req_ready_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_perr_q   <= 1'b0;
            rx_ferr_q   <= 1'b0;
            ovf_q       <= 1'b0;
            perr_cnt_q  <= '0;
            ferr_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            grant_q     <= grant_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            data_in_q   <= data_in_d;
            req_ready_q <= req_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_perr_q   <= rx_perr_d;
            rx_ferr_q   <= rx_ferr_d;
            ovf_q       <= ovf_d;
            perr_cnt_q  <= perr_cnt_d;
            ferr_cnt_q  <= ferr_cnt_d;
        end
    end

    assign bus.uart_csn        = csn_q;
    assign bus.uart_wen        = wen_q;
    assign bus.uart_oen        = oen_q;
    assign bus.uart_data_in    = data_in_q;
    assign bus.req_ready       = req_ready_q;
    assign bus.rx_valid        = rx_valid_q;
    assign bus.rx_data         = rx_data_q;
    assign bus.rx_perr         = rx_perr_q;
    assign bus.rx_ferr         = rx_ferr_q;
    assign bus.overflow_sticky = ovf_q;
    assign bus.perr_cnt        = perr_cnt_q;
    assign bus.ferr_cnt        = ferr_cnt_q;

endmodule

// File: tb/tb_uart_core_ctrl.sv
// Directed bench for uart_core_ctrl: expected strobe events go into a queue
// and an independent monitor pops and compares them as the DUT emits them.
module tb_uart_core_ctrl;

    localparam int NUM_REQ = 2;
    localparam int SETTLE  = 2;
    localparam int CNT_W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_core_ctrl_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    uart_core_ctrl #(
        .NUM_REQ (NUM_REQ),
        .SETTLE  (SETTLE),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    typedef struct {
        bit                 isWrite;
        logic [7:0]         data;
        logic [NUM_REQ-1:0] ready;
        logic               perr;
        logic               ferr;
    } expT;

    expT expQ[$];
    expT monGot;
    int  compares = 0;
    int  fails    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushWrite(input logic [7:0] d, input logic [NUM_REQ-1:0] r);
        expT e;
        e.isWrite = 1'b1; e.data = d; e.ready = r; e.perr = 1'b0; e.ferr = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic pushRead(input logic [7:0] d, input logic p, input logic f);
        expT e;
        e.isWrite = 1'b0; e.data = d; e.ready = '0; e.perr = p; e.ferr = f;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [15:0] data,
                                 input logic txrdy, input logic rxrdy, input logic [7:0] dout);
        nextCycle();
        bus.req_valid     = valid;
        bus.req_data      = data;
        bus.uart_txrdy    = txrdy;
        bus.uart_rxrdy    = rxrdy;
        bus.uart_data_out = dout;
    endtask

    task automatic waitStrobe(input bit isWrite, input int budget, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (!bus.uart_csn && (isWrite ? !bus.uart_wen : !bus.uart_oen)) seen = 1'b1;
        end
        if (!seen) begin
            compares++;
            fails++;
            $display("[TB] FAIL %s: strobe not seen within %0d cycles, want one", name, budget);
        end
    endtask

    // Monitor: every strobe consumes one expected event from the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.uart_csn && !bus.uart_wen) begin
                if (expQ.size() == 0) begin
                    compares++;
                    fails++;
                    $display("[TB] FAIL unexpected write: got data 0x%0h, want no write", bus.uart_data_in);
                end else begin
                    monGot = expQ.pop_front();
                    checkOutput("write slot kind", {31'b0, monGot.isWrite}, 32'd1);
                    checkOutput("write data", 32'(bus.uart_data_in), 32'(monGot.data));
                    checkOutput("write grant", 32'(bus.req_ready), 32'(monGot.ready));
                end
            end else if (bus.req_ready != '0) begin
                compares++;
                fails++;
                $display("[TB] FAIL stray req_ready: got 0x%0h, want 0 outside write strobe", bus.req_ready);
            end
            if (!bus.uart_csn && !bus.uart_oen) begin
                if (expQ.size() == 0) begin
                    compares++;
                    fails++;
                    $display("[TB] FAIL unexpected read: got oen pulse, want none");
                end else begin
                    monGot = expQ.pop_front();
                    checkOutput("read slot kind", {31'b0, monGot.isWrite}, 32'd0);
                    checkOutput("read rx_valid", 32'(bus.rx_valid), 32'd1);
                    checkOutput("read rx_data", 32'(bus.rx_data), 32'(monGot.data));
                    checkOutput("read rx_perr", 32'(bus.rx_perr), 32'(monGot.perr));
                    checkOutput("read rx_ferr", 32'(bus.rx_ferr), 32'(monGot.ferr));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants;
        int gap;
        bit seenW;

        bus.req_valid = '0;      bus.req_data = '0;     bus.rx_ready = 1'b0;
        bus.err_clr = 1'b0;      bus.uart_data_out = '0;
        bus.uart_txrdy = 1'b0;   bus.uart_rxrdy = 1'b0;
        bus.uart_perr = 1'b0;    bus.uart_ferr = 1'b0;  bus.uart_ovf = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset csn", 32'(bus.uart_csn), 32'd1);
        checkOutput("reset wen", 32'(bus.uart_wen), 32'd1);
        checkOutput("reset oen", 32'(bus.uart_oen), 32'd1);
        checkOutput("reset data_in", 32'(bus.uart_data_in), 32'd0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        checkOutput("reset rx_data", 32'(bus.rx_data), 32'd0);
        checkOutput("reset overflow", 32'(bus.overflow_sticky), 32'd0);
        checkOutput("reset perr_cnt", 32'(bus.perr_cnt), 32'd0);
        checkOutput("reset ferr_cnt", 32'(bus.ferr_cnt), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        idleCycles(3);

        // Round robin with both requesters always valid.
        pushWrite(8'hA0, 2'b01); pushWrite(8'hB1, 2'b10);
        pushWrite(8'hA0, 2'b01); pushWrite(8'hB1, 2'b10);
        applyStimulus(2'b11, 16'hB1A0, 1'b1, 1'b0, 8'h00);
        grants = 0;
        for (int c = 0; c < 100 && grants < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) grants++;
        end
        checkOutput("rr write count", 32'(grants), 32'd4);
        nextCycle();
        bus.req_valid = '0;
        idleCycles(8);

        // Single write and its request-to-ready latency.
        pushWrite(8'h55, 2'b01);
        applyStimulus(2'b01, 16'h0055, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("tx latency c0", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        checkOutput("tx latency c1", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        checkOutput("tx latency c2", 32'(bus.req_ready), 32'd1);
        nextCycle();
        bus.req_valid = '0;
        idleCycles(8);

        // RX wins over a simultaneous TX request.
        pushRead(8'h3C, 1'b0, 1'b0);
        pushWrite(8'h5A, 2'b01);
        applyStimulus(2'b01, 16'h005A, 1'b1, 1'b1, 8'h3C);
        waitStrobe(1'b0, 10, "rx prio read");
        gap = 0;
        seenW = 1'b0;
        for (int c = 0; c < 20 && !seenW; c++) begin
            @(negedge clk);
            gap++;
            if (!bus.uart_csn && !bus.uart_wen) seenW = 1'b1;
        end
        checkOutput("rx prio write gap", 32'(gap), 32'(SETTLE + 2));
        nextCycle();
        bus.req_valid = '0;
        bus.uart_rxrdy = 1'b0;
        checkOutput("rx prio held data", 32'(bus.rx_data), 32'h3C);
        nextCycle();
        bus.rx_ready = 1'b1;
        nextCycle();
        bus.rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("rx consume clears", 32'(bus.rx_valid), 32'd0);
        idleCycles(6);

        // Stalled consumer: no second read, overflow flagged.
        pushRead(8'h11, 1'b0, 1'b0);
        applyStimulus('0, 16'h0000, 1'b0, 1'b1, 8'h11);
        waitStrobe(1'b0, 10, "bp first read");
        nextCycle();
        bus.uart_data_out = 8'h22;
        repeat (12) @(negedge clk);
        checkOutput("bp data held", 32'(bus.rx_data), 32'h11);
        checkOutput("bp valid held", 32'(bus.rx_valid), 32'd1);
        checkOutput("bp overflow before", 32'(bus.overflow_sticky), 32'd0);
        nextCycle();
        bus.uart_ovf = 1'b1;
        nextCycle();
        bus.uart_ovf = 1'b0;
        @(negedge clk);
        checkOutput("bp overflow sticky", 32'(bus.overflow_sticky), 32'd1);
        pushRead(8'h22, 1'b0, 1'b0);
        nextCycle();
        bus.rx_ready = 1'b1;
        waitStrobe(1'b0, 10, "bp drain read");
        nextCycle();
        bus.uart_rxrdy = 1'b0;
        idleCycles(4);
        checkOutput("bp drained", 32'(bus.rx_valid), 32'd0);
        bus.err_clr = 1'b1;
        nextCycle();
        bus.err_clr = 1'b0;
        @(negedge clk);
        checkOutput("overflow cleared", 32'(bus.overflow_sticky), 32'd0);
        idleCycles(4);

        // 300 parity-error reads saturate the counter.
        for (int n = 0; n < 300; n++) pushRead(8'h77, 1'b1, 1'b0);
        applyStimulus('0, 16'h0000, 1'b0, 1'b1, 8'h77);
        bus.uart_perr = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            waitStrobe(1'b0, 20, "perr read");
            if (n == 100) checkOutput("perr_cnt at 100", 32'(bus.perr_cnt), 32'd100);
            if (n == 255) checkOutput("perr_cnt at 255", 32'(bus.perr_cnt), 32'd255);
        end
        nextCycle();
        bus.uart_rxrdy = 1'b0;
        bus.uart_perr = 1'b0;
        idleCycles(6);
        checkOutput("perr_cnt saturated", 32'(bus.perr_cnt), 32'd255);
        checkOutput("ferr_cnt untouched", 32'(bus.ferr_cnt), 32'd0);

        // err_clr in the same cycle as a parity-error read.
        pushRead(8'h66, 1'b1, 1'b0);
        applyStimulus('0, 16'h0000, 1'b0, 1'b1, 8'h66);
        bus.uart_perr = 1'b1;
        nextCycle();
        bus.err_clr = 1'b1;
        nextCycle();
        bus.err_clr = 1'b0;
        bus.uart_rxrdy = 1'b0;
        bus.uart_perr = 1'b0;
        @(negedge clk);
        checkOutput("err_clr beats perr", 32'(bus.perr_cnt), 32'd0);
        idleCycles(6);

        pushRead(8'h99, 1'b0, 1'b1);
        applyStimulus('0, 16'h0000, 1'b0, 1'b1, 8'h99);
        bus.uart_ferr = 1'b1;
        waitStrobe(1'b0, 10, "ferr read");
        nextCycle();
        bus.uart_rxrdy = 1'b0;
        bus.uart_ferr = 1'b0;
        idleCycles(4);
        checkOutput("ferr_cnt one", 32'(bus.ferr_cnt), 32'd1);
        checkOutput("perr_cnt stays", 32'(bus.perr_cnt), 32'd0);

        // Asynchronous reset while in WR_WAIT.
        pushWrite(8'h42, 2'b01);
        applyStimulus(2'b01, 16'h0042, 1'b1, 1'b0, 8'h00);
        waitStrobe(1'b1, 10, "pre-reset write");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst csn", 32'(bus.uart_csn), 32'd1);
        checkOutput("async rst wen", 32'(bus.uart_wen), 32'd1);
        checkOutput("async rst req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("async rst data_in", 32'(bus.uart_data_in), 32'd0);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        checkOutput("async rst rx_valid", 32'(bus.rx_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        pushWrite(8'hA0, 2'b01);
        applyStimulus(2'b11, 16'hB1A0, 1'b1, 1'b0, 8'h00);
        waitStrobe(1'b1, 10, "post-reset write");
        nextCycle();
        bus.req_valid = '0;
        idleCycles(8);

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
